// File: rtl/des_pkg.sv
// Shared DES constants for the descrypt round slices: S-box contents, the P permutation,
// and datapath widths. Tables are stored flat, S1 (and P position 1) leftmost.
package des_pkg;

  localparam int unsigned E_W    = 48;
  localparam int unsigned HALF_W = 32;
  localparam int unsigned SALT_W = 12;
  localparam int unsigned SBOX_N = 8;

  // Each 256-bit chunk is one S-box, rows 0..3 left to right, 16 nibbles per row.
  localparam logic [SBOX_N*256-1:0] S_TABLE = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // 1-based source bit of the S-box output for each P output position.
  localparam logic [HALF_W*6-1:0] P_TABLE = {
    6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
    6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
    6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
    6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
  };

  // sel is 1..8, idx is row*16+col.
  function automatic logic [3:0] sbox_lookup(input int unsigned sel, input logic [5:0] idx);
    int unsigned base;
    base = (SBOX_N * 256 - 1) - ((sel - 1) * 256 + 4 * 32'(idx));
    return S_TABLE[base -: 4];
  endfunction

  // j is the 0-based P output position; result is the 1-based DES source bit.
  function automatic int unsigned p_src(input int unsigned j);
    return 32'(P_TABLE[HALF_W * 6 - 1 - 6 * j -: 6]);
  endfunction

endpackage

// File: rtl/des_keymix_sbox_stage_if.sv
// Beat-level handshake bundle for one keymix/S-box round stage, plus the salt load port.
// Vectors use DES numbering mapped MSB-first: DES bit 0 is the vector MSB.
interface des_keymix_sbox_stage_if
  import des_pkg::*;
#(
  parameter int unsigned TAG_W = 8
) ();

  logic              salt_ld;
  logic [SALT_W-1:0] salt_in;

  logic              in_valid;
  logic              in_ready;
  logic [E_W-1:0]    e_in;
  logic [E_W-1:0]    k_in;
  logic [HALF_W-1:0] l_in;
  logic [HALF_W-1:0] r_in;
  logic [TAG_W-1:0]  tag_in;

  logic              out_valid;
  logic              out_ready;
  logic [HALF_W-1:0] l_out;
  logic [HALF_W-1:0] r_out;
  logic [TAG_W-1:0]  tag_out;

  modport master (
    output salt_ld, salt_in, in_valid, e_in, k_in, l_in, r_in, tag_in, out_ready,
    input  in_ready, out_valid, l_out, r_out, tag_out
  );

  modport slave (
    input  salt_ld, salt_in, in_valid, e_in, k_in, l_in, r_in, tag_in, out_ready,
    output in_ready, out_valid, l_out, r_out, tag_out
  );

endinterface

// File: rtl/des_sbox.sv
// Single DES S-box: 6-bit group b0..b5 (b0 = MSB) in, 4-bit value out.
// Row is {b0,b5}, column is b1..b4.
module des_sbox
  import des_pkg::*;
#(
  parameter int unsigned SEL = 1
) (
  input  logic [5:0] addr_i,
  output logic [3:0] data_o
);

  logic [5:0] idx;

  always_comb begin
    idx    = {addr_i[5], addr_i[0], addr_i[4:1]};
    data_o = sbox_lookup(SEL, idx);
  end

endmodule

// File: rtl/des_keymix_sbox_stage.sv
// Back half of a descrypt round: salt swap, subkey XOR, S1..S8, P and the L XOR, split across
// two register stages with a valid/ready handshake that never inserts a bubble.
module des_keymix_sbox_stage
  import des_pkg::*;
#(
  parameter int unsigned TAG_W = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  des_keymix_sbox_stage_if.slave bus
);

  logic [SALT_W-1:0] salt_q, salt_d;

  logic              s1_v_q, s1_v_d;
  logic [E_W-1:0]    s1_x_q, s1_x_d;
  logic [HALF_W-1:0] s1_l_q, s1_l_d;
  logic [HALF_W-1:0] s1_r_q, s1_r_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

  logic              s2_v_q, s2_v_d;
  logic [HALF_W-1:0] s2_l_q, s2_l_d;
  logic [HALF_W-1:0] s2_r_q, s2_r_d;
  logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;

  logic              s2_adv;
  logic              in_ready;
  logic [E_W-1:0]    e_sw;
  logic [E_W-1:0]    x_in;
  logic [HALF_W-1:0] s_out;
  logic [HALF_W-1:0] p_out;
  logic [HALF_W-1:0] f_res;

  // DES bit i sits at vector index E_W-1-i; the swap pairs DES bits i and i+24.
  always_comb begin
    e_sw = bus.e_in;
    for (int i = 0; i < SALT_W; i++) begin
      if (salt_q[SALT_W-1-i]) begin
        e_sw[E_W-1-i]   = bus.e_in[E_W/2-1-i];
        e_sw[E_W/2-1-i] = bus.e_in[E_W-1-i];
      end
    end
    x_in = e_sw ^ bus.k_in;
  end

  for (genvar g = 0; g < SBOX_N; g++) begin : gen_sbox
    des_sbox #(
      .SEL(g + 1)
    ) u_sbox (
      .addr_i(s1_x_q[E_W-1-6*g -: 6]),
      .data_o(s_out[HALF_W-1-4*g -: 4])
    );
  end

  always_comb begin
    p_out = '0;
    for (int j = 0; j < HALF_W; j++) begin
      p_out[HALF_W-1-j] = s_out[HALF_W-p_src(j)];
    end
    f_res = s1_l_q ^ p_out;
  end

  // S1 may refill in the same cycle S2 drains, so a full pipe still streams at full rate.
  always_comb begin
    s2_adv   = !s2_v_q || bus.out_ready;
    in_ready = !s1_v_q || s2_adv;

    salt_d   = bus.salt_ld ? bus.salt_in : salt_q;

    s1_v_d   = s1_v_q;
    s1_x_d   = s1_x_q;
    s1_l_d   = s1_l_q;
    s1_r_d   = s1_r_q;
    s1_tag_d = s1_tag_q;
    if (in_ready) begin
      s1_v_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_x_d   = x_in;
        s1_l_d   = bus.l_in;
        s1_r_d   = bus.r_in;
        s1_tag_d = bus.tag_in;
      end
    end

    s2_v_d   = s2_v_q;
    s2_l_d   = s2_l_q;
    s2_r_d   = s2_r_q;
    s2_tag_d = s2_tag_q;
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_l_d   = s1_r_q;
        s2_r_d   = f_res;
        s2_tag_d = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      salt_q   <= '0;
      s1_v_q   <= 1'b0;
      s1_x_q   <= '0;
      s1_l_q   <= '0;
      s1_r_q   <= '0;
      s1_tag_q <= '0;
      s2_v_q   <= 1'b0;
      s2_l_q   <= '0;
      s2_r_q   <= '0;
      s2_tag_q <= '0;
    end else begin
      salt_q   <= salt_d;
      s1_v_q   <= s1_v_d;
      s1_x_q   <= s1_x_d;
      s1_l_q   <= s1_l_d;
      s1_r_q   <= s1_r_d;
      s1_tag_q <= s1_tag_d;
      s2_v_q   <= s2_v_d;
      s2_l_q   <= s2_l_d;
      s2_r_q   <= s2_r_d;
      s2_tag_q <= s2_tag_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_v_q;
  assign bus.l_out     = s2_l_q;
  assign bus.r_out     = s2_r_q;
  assign bus.tag_out   = s2_tag_q;

endmodule

// File: tb/tb_des_keymix_sbox_stage.sv
// Bench for des_keymix_sbox_stage: directed beats, a DES-numbered reference f-function with its
// own tables, a scoreboard checked every cycle, and literal results that pin the reference.
module tb_des_keymix_sbox_stage;

  localparam int unsigned TAG_W = 8;

  localparam bit [63:0] SROW [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  localparam int PT [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
  };

  typedef struct {
    logic [31:0]      l;
    logic [31:0]      r;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rand_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int out_cnt  = 0;

  exp_t        exp_q [$];
  logic [11:0] model_salt = '0;
  logic [31:0] r_by_tag [256];
  bit          hold_chk = 1'b0;
  logic [71:0] held;

  always #5 clk = ~clk;

  des_keymix_sbox_stage_if #(.TAG_W(TAG_W)) bus ();

  des_keymix_sbox_stage #(
    .TAG_W(TAG_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference f-function in DES bit numbering (index 0 = first/most significant bit).
  function automatic logic [31:0] model_f(input logic [47:0] e, input logic [47:0] k,
                                          input logic [31:0] l, input logic [11:0] salt);
    bit          eb [48];
    bit          sb [32];
    bit          t;
    bit [63:0]   row_v;
    logic [1:0]  row;
    logic [3:0]  col;
    logic [3:0]  v;
    logic [31:0] r;
    for (int i = 0; i < 48; i++) eb[i] = e[47-i];
    for (int i = 0; i < 12; i++) begin
      if (salt[11-i]) begin
        t        = eb[i];
        eb[i]    = eb[i+24];
        eb[i+24] = t;
      end
    end
    for (int i = 0; i < 48; i++) eb[i] = eb[i] ^ k[47-i];
    for (int s = 0; s < 8; s++) begin
      row   = {eb[6*s], eb[6*s+5]};
      col   = {eb[6*s+1], eb[6*s+2], eb[6*s+3], eb[6*s+4]};
      row_v = SROW[s*4+int'(row)];
      v     = row_v[(15-int'(col))*4 +: 4];
      for (int j = 0; j < 4; j++) sb[4*s+j] = v[3-j];
    end
    for (int j = 0; j < 32; j++) r[31-j] = l[31-j] ^ sb[PT[j]-1];
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Everything is stable at the falling edge; what is seen here transfers at the next rise.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_salt = '0;
      hold_chk   = 1'b0;
    end else begin
      check("in_ready", 128'(bus.in_ready),
            128'(!(exp_q.size() == 2 && !bus.out_ready)));
      if (exp_q.size() == 0) check("empty_out_valid", 128'(bus.out_valid), 128'(0));
      if (exp_q.size() == 2) check("full_out_valid", 128'(bus.out_valid), 128'(1));
      if (hold_chk) begin
        check("stall_hold", 128'({bus.out_valid, bus.l_out, bus.r_out, bus.tag_out}),
              128'({1'b1, held}));
      end
      hold_chk = bus.out_valid && !bus.out_ready;
      held     = {bus.l_out, bus.r_out, bus.tag_out};
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        r_by_tag[bus.tag_out] = bus.r_out;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 128'(1), 128'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("l_out", 128'(bus.l_out), 128'(e.l));
          check("r_out", 128'(bus.r_out), 128'(e.r));
          check("tag_out", 128'(bus.tag_out), 128'(e.tag));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        e.l   = bus.r_in;
        e.r   = model_f(bus.e_in, bus.k_in, bus.l_in, model_salt);
        e.tag = bus.tag_in;
        exp_q.push_back(e);
      end
      if (bus.salt_ld) model_salt = bus.salt_in;
    end
  end

  task automatic send(input logic [47:0] e, input logic [47:0] k, input logic [31:0] l,
                      input logic [31:0] r, input logic [7:0] tag, input logic ld,
                      input logic [11:0] salt);
    bit accepted = 1'b0;
    int guard    = 0;
    bus.e_in     = e;
    bus.k_in     = k;
    bus.l_in     = l;
    bus.r_in     = r;
    bus.tag_in   = tag;
    bus.salt_ld  = ld;
    bus.salt_in  = salt;
    bus.in_valid = 1'b1;
    while (!accepted && guard < 100) begin
      @(negedge clk);
      accepted = bus.in_ready;
      guard++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.salt_ld  = 1'b0;
    if (!accepted) check("send_timeout", 128'(0), 128'(1));
  endtask

  task automatic load_salt(input logic [11:0] salt);
    bus.salt_ld = 1'b1;
    bus.salt_in = salt;
    @(posedge clk);
    #1;
    bus.salt_ld = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("drain", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int cnt0;
    rst_n        = 1'b1;
    bus.salt_ld  = 1'b0;
    bus.salt_in  = '0;
    bus.in_valid = 1'b0;
    bus.e_in     = '0;
    bus.k_in     = '0;
    bus.l_in     = '0;
    bus.r_in     = '0;
    bus.tag_in   = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_l_out", 128'(bus.l_out), 128'(0));
    check("rst_r_out", 128'(bus.r_out), 128'(0));
    check("rst_tag_out", 128'(bus.tag_out), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));

    // All-zero inputs, with exact two-edge latency.
    send(48'h0, 48'h0, 32'h0, 32'h12345678, 8'd1, 1'b0, 12'h0);
    check("t1_valid_after_1", 128'(bus.out_valid), 128'(0));
    @(posedge clk);
    #1;
    check("t1_valid_after_2", 128'(bus.out_valid), 128'(1));
    check("t1_r_out", 128'(bus.r_out), 128'(32'hD8D8DBBC));
    check("t1_l_out", 128'(bus.l_out), 128'(32'h12345678));
    check("t1_tag", 128'(bus.tag_out), 128'(8'd1));
    drain();

    send(48'h0, 48'h0, 32'hFFFFFFFF, 32'hCAFEF00D, 8'd2, 1'b0, 12'h0);
    drain();
    check("t2_r_out", 128'(r_by_tag[2]), 128'(32'h27272443));

    // Salt bit 0 moves E bit 0 to bit 24.
    load_salt(12'h800);
    send(48'h800000000000, 48'h0, 32'h0, 32'h1, 8'd3, 1'b0, 12'h0);
    load_salt(12'h000);
    send(48'h000000800000, 48'h0, 32'h0, 32'h2, 8'd4, 1'b0, 12'h0);
    send(48'h800000000000, 48'h0, 32'h0, 32'h3, 8'd5, 1'b0, 12'h0);
    drain();
    check("t3_salted", 128'(r_by_tag[3]), 128'(32'hD8DCDB3C));
    check("t3_moved_bit", 128'(r_by_tag[4]), 128'(32'hD8DCDB3C));
    check("t3_unsalted", 128'(r_by_tag[5]), 128'(32'hD858D9BC));
    check("t3_differs", 128'(r_by_tag[5] != r_by_tag[3]), 128'(1));

    // Random backpressure on a stream of ten tagged beats with occasional input gaps.
    rand_ready = 1'b1;
    cnt0 = out_cnt;
    for (int i = 0; i < 10; i++) begin
      send({$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom,
           8'(10 + i), 1'b0, 12'h0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rand_ready = 1'b0;
    check("t4_beat_count", 128'(out_cnt - cnt0), 128'(10));

    // Salt load coincident with a transfer: that beat sees the old salt.
    send(48'h800000000000, 48'h0, 32'h0, 32'h30, 8'd30, 1'b1, 12'h800);
    send(48'h800000000000, 48'h0, 32'h0, 32'h31, 8'd31, 1'b0, 12'h0);
    drain();
    check("t5_old_salt", 128'(r_by_tag[30]), 128'(32'hD858D9BC));
    check("t5_new_salt", 128'(r_by_tag[31]), 128'(32'hD8DCDB3C));

    // Reset with two beats in flight; salt also returns to zero.
    send(48'h0, 48'h0, 32'h0, 32'h40, 8'd40, 1'b0, 12'h0);
    send(48'h0, 48'h0, 32'h0, 32'h41, 8'd41, 1'b0, 12'h0);
    rst_n = 1'b0;
    #1;
    check("t6_async_drop", 128'(bus.out_valid), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt0 = out_cnt;
    send(48'h800000000000, 48'h0, 32'h0, 32'h42, 8'd42, 1'b0, 12'h0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("t6_one_beat", 128'(out_cnt - cnt0), 128'(1));
    check("t6_r_out", 128'(r_by_tag[42]), 128'(32'hD858D9BC));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
